// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: per-register pending-write counters that gate issue.
// Optional SB_WB_BYPASS_EN lets a reader issue in the same cycle as its producer's write-back.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2,
  parameter int TW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_wen,
  output logic          issue_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic          flush,
  output logic [TW-1:0] inflight,
  output logic          err
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt [1:NREG-1];

  logic [CW-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt, rd_cnt_eff;
  logic          rs1_haz, rs2_haz, rd_haz;
  logic          accept, inc_en, dec_en, wb_zero;

  // Register 0 is untracked, so every lookup defaults to zero and only 1..NREG-1 override.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    wb_cnt  = '0;
    for (int i = 1; i < NREG; i++) begin
      if (issue_rs1 == AW'(i)) rs1_cnt = cnt[i];
      if (issue_rs2 == AW'(i)) rs2_cnt = cnt[i];
      if (issue_rd  == AW'(i)) rd_cnt  = cnt[i];
      if (wb_rd     == AW'(i)) wb_cnt  = cnt[i];
    end
  end

  always_comb begin
    rd_cnt_eff = rd_cnt;
    if (wb_valid && (wb_rd == issue_rd) && (rd_cnt != '0))
      rd_cnt_eff = rd_cnt - CNT_ONE;
  end

`ifdef SB_WB_BYPASS_EN
  // The bank writes in clock-high and reads in clock-low, so a last pending write
  // retiring this cycle is already visible to a reader issuing this cycle.
  assign rs1_haz = (rs1_cnt != '0) &&
                   !((rs1_cnt == CNT_ONE) && wb_valid && (wb_rd == issue_rs1));
  assign rs2_haz = (rs2_cnt != '0) &&
                   !((rs2_cnt == CNT_ONE) && wb_valid && (wb_rd == issue_rs2));
`else
  assign rs1_haz = (rs1_cnt != '0);
  assign rs2_haz = (rs2_cnt != '0);
`endif

  assign rd_haz      = issue_wen && (issue_rd != '0) && (rd_cnt_eff == CNT_MAX);
  assign issue_ready = !rs1_haz && !rs2_haz && !rd_haz;

  assign accept  = issue_valid && issue_ready && !flush;
  assign inc_en  = accept && issue_wen && (issue_rd != '0);
  assign dec_en  = wb_valid && (wb_rd != '0) && (wb_cnt != '0);
  assign wb_zero = wb_valid && (wb_rd != '0) && (wb_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) cnt[i] <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      for (int i = 1; i < NREG; i++) cnt[i] <= '0;
      inflight <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc_en && (issue_rd == AW'(i)) && !(dec_en && (wb_rd == AW'(i))))
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_en && (wb_rd == AW'(i)) && !(inc_en && (issue_rd == AW'(i))))
          cnt[i] <= cnt[i] - CNT_ONE;
      end
      inflight <= inflight + TW'(inc_en) - TW'(dec_en);
      if (wb_zero) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus randomized bench for reg_scoreboard against an array-based reference model.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_wen, wb_valid, flush;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic       issue_ready;
  logic [5:0] inflight;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [32];
  int m_infl;
  bit m_err;

`ifdef SB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .inflight(inflight), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit src_blocked(int rs, bit wbv, int wbr);
    if (rs == 0 || m_cnt[rs] == 0) return 1'b0;
    if (BYPASS && m_cnt[rs] == 1 && wbv && wbr == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready(int rs1, int rs2, int rd, bit wen, bit wbv, int wbr);
    int pend;
    pend = m_cnt[rd];
    if (wbv && wbr == rd && pend > 0) pend--;
    if (src_blocked(rs1, wbv, wbr) || src_blocked(rs2, wbv, wbr)) return 1'b0;
    if (wen && rd != 0 && pend == 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear(bit clr_err);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_infl = 0;
    if (clr_err) m_err = 1'b0;
  endtask

  // Called one time unit after a rising edge: drive, check ready at the falling
  // edge, then clock the model alongside the DUT and check registered outputs.
  task automatic cyc(string tag, bit v, int rs1, int rs2, int rd, bit wen,
                     bit wbv, int wbr, bit fl);
    bit rdy;
    issue_valid = v; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd);
    issue_wen = wen; wb_valid = wbv; wb_rd = 5'(wbr); flush = fl;
    rdy = model_ready(rs1, rs2, rd, wen, wbv, wbr);
    #4;
    chk({tag, ".ready"}, 32'(issue_ready), 32'(rdy));
    @(posedge clk);
    if (fl) model_clear(1'b0);
    else begin
      if (wbv && wbr != 0) begin
        if (m_cnt[wbr] > 0) begin m_cnt[wbr]--; m_infl--; end
        else m_err = 1'b1;
      end
      if (v && rdy && wen && rd != 0) begin m_cnt[rd]++; m_infl++; end
    end
    #1;
    chk({tag, ".inflight"}, 32'(inflight), 32'(m_infl));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_valid = 0; issue_wen = 0; wb_valid = 0; flush = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; wb_rd = 0;
    @(posedge clk); #1;
    model_clear(1'b1);
    rst_n = 1'b1;
    chk("reset.inflight", 32'(inflight), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    m_err = 1'b0;
    model_clear(1'b1);
    @(posedge clk); #1;
    do_reset();

    // first issue after reset, then RAW hazard and release
    cyc("first", 1, 3, 4, 5, 1, 0, 0, 0);
    chk("first.infl1", 32'(inflight), 32'd1);
    cyc("raw_hold", 1, 5, 0, 6, 0, 0, 0, 0);
    chk("raw_hold.rdy0", 32'(issue_ready), 32'd0);
    cyc("raw_wb", 1, 5, 0, 6, 0, 1, 5, 0);
    cyc("raw_after", 1, 5, 0, 6, 0, 0, 0, 0);
    chk("raw_after.rdy1", 32'(issue_ready), 32'd1);

    // destination saturation at 3 writers
    do_reset();
    for (int k = 0; k < 3; k++) cyc("sat_fill", 1, 0, 0, 7, 1, 0, 0, 0);
    cyc("sat_hold", 1, 0, 0, 7, 1, 0, 0, 0);
    chk("sat_hold.infl3", 32'(inflight), 32'd3);
    cyc("sat_wb", 1, 0, 0, 7, 1, 1, 7, 0);
    chk("sat_wb.infl3", 32'(inflight), 32'd3);
    cyc("sat_again", 1, 7, 0, 7, 1, 0, 0, 0);

    // register-0 traffic
    do_reset();
    for (int k = 0; k < 4; k++) cyc("zero", 1, 0, 0, 0, 1, 1, 0, 0);

    // spurious write-back, sticky through flush
    cyc("err_set", 0, 0, 0, 0, 0, 1, 9, 0);
    chk("err_set.err1", 32'(err), 32'd1);
    cyc("err_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    // flush beats same-cycle issue and write-back
    for (int k = 10; k < 14; k++) cyc("fl_fill", 1, 0, 0, k, 1, 0, 0, 0);
    chk("fl_fill.infl4", 32'(inflight), 32'd4);
    cyc("fl", 1, 0, 0, 14, 1, 1, 10, 1);
    cyc("fl_after_a", 1, 10, 11, 14, 1, 0, 0, 0);
    cyc("fl_after_b", 1, 12, 13, 0, 0, 1, 14, 0);

    // randomized traffic on registers 0..15 keeps inflight below 2^6
    do_reset();
    for (int k = 0; k < 600; k++) begin
      cyc("rand", ($urandom_range(9) < 8), $urandom_range(15), $urandom_range(15),
          $urandom_range(15), ($urandom_range(9) < 7), $urandom_range(1),
          $urandom_range(15), ($urandom_range(99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
